// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream boot loader for the CPU instruction RAM (optional LOADER_CHECKSUM_EN)
module imem_loader #(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic [7:0]    RxData,
  input  logic          RxValid,
  output logic          RxReady,
  output logic          WE,
  output logic [31:0]   WAddr,
  output logic [31:0]   WData,
  output logic          CpuHold,
  output logic          Done,
  output logic          Error,
  output logic [AW:0]   WordCount
);

  // Header limit as a byte, so the header compare stays 8 bits wide.
  localparam logic [7:0] DEPTH_B = 8'(DEPTH);
  localparam logic [AW:0] ONE    = (AW+1)'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
`ifdef LOADER_CHECKSUM_EN
    S_CHECK,
`endif
    S_DONE,
    S_ERROR
  } state_t;

  state_t       state_q, state_d;
  logic [23:0]  shift_q, shift_d;   // first three bytes of the word in flight
  logic [1:0]   bcnt_q, bcnt_d;     // byte position within the current word
  logic [AW:0]  cnt_q, cnt_d;       // word index, doubles as WordCount
  logic [AW:0]  n_q, n_d;           // word count announced by the header
  logic         we_q, we_d;
  logic [31:0]  waddr_q, waddr_d;
  logic [31:0]  wdata_q, wdata_d;
  logic         rx_ready_q;
  logic         cpu_hold_q;
  logic         done_q;
  logic         error_q;
  logic         xfer;
  logic [31:0]  word;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]   csum_q, csum_d;
`endif

  assign xfer = RxValid && rx_ready_q;
  assign word = {shift_q, RxData};

  // Next-state and datapath updates for the load sequence.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bcnt_d  = bcnt_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          state_d = S_HDR;
          cnt_d   = '0;
        end
      end
      S_HDR: begin
        if (xfer) begin
          if (RxData == 8'd0 || RxData > DEPTH_B) begin
            state_d = S_ERROR;
          end else begin
            n_d     = RxData[AW:0];
            cnt_d   = '0;
            bcnt_d  = 2'd0;
`ifdef LOADER_CHECKSUM_EN
            csum_d  = 8'd0;
`endif
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          shift_d = word[23:0];
          bcnt_d  = bcnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
          csum_d  = csum_q ^ RxData;
`endif
          if (bcnt_q == 2'd3) begin
            // Word complete: the write strobe and the index bump land on the same edge.
            we_d    = 1'b1;
            waddr_d = {{(30-AW){1'b0}}, cnt_q[AW-1:0], 2'b00};
            wdata_d = word;
            cnt_d   = cnt_q + ONE;
            if (cnt_q + ONE == n_q) begin
`ifdef LOADER_CHECKSUM_EN
              state_d = S_CHECK;
`else
              state_d = S_DONE;
`endif
            end
          end
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (xfer) begin
          state_d = (RxData == csum_q) ? S_DONE : S_ERROR;
        end
      end
`endif
      S_DONE, S_ERROR: begin
        if (Start) begin
          state_d = S_HDR;
          cnt_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, datapath and registered outputs derived from the next state.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      bcnt_q     <= '0;
      cnt_q      <= '0;
      n_q        <= '0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      rx_ready_q <= 1'b0;
      cpu_hold_q <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bcnt_q     <= bcnt_d;
      cnt_q      <= cnt_d;
      n_q        <= n_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
`ifdef LOADER_CHECKSUM_EN
      rx_ready_q <= (state_d == S_HDR) || (state_d == S_DATA) || (state_d == S_CHECK);
      cpu_hold_q <= (state_d == S_HDR) || (state_d == S_DATA) || (state_d == S_CHECK) ||
                    (state_d == S_ERROR);
`else
      rx_ready_q <= (state_d == S_HDR) || (state_d == S_DATA);
      cpu_hold_q <= (state_d == S_HDR) || (state_d == S_DATA) || (state_d == S_ERROR);
`endif
      done_q     <= (state_d == S_DONE);
      error_q    <= (state_d == S_ERROR);
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // Running XOR of the data bytes, compared against the trailing byte.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      csum_q <= 8'd0;
    end else begin
      csum_q <= csum_d;
    end
  end
`endif

  assign RxReady   = rx_ready_q;
  assign WE        = we_q;
  assign WAddr     = waddr_q;
  assign WData     = wdata_q;
  assign CpuHold   = cpu_hold_q;
  assign Done      = done_q;
  assign Error     = error_q;
  assign WordCount = cnt_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader against a byte-stream reference model
module tb_imem_loader;
  localparam int DEPTH = 32;
  localparam int AW    = 5;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Start;
  logic [7:0]  RxData;
  logic        RxValid;
  logic        RxReady;
  logic        WE;
  logic [31:0] WAddr;
  logic [31:0] WData;
  logic        CpuHold;
  logic        Done;
  logic        Error;
  logic [AW:0] WordCount;

  imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .RxData(RxData), .RxValid(RxValid),
    .RxReady(RxReady), .WE(WE), .WAddr(WAddr), .WData(WData), .CpuHold(CpuHold),
    .Done(Done), .Error(Error), .WordCount(WordCount)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  logic [63:0] got_q[$];
  logic [63:0] exp_q[$];
  logic [7:0]  stim[$];
  bit          exp_done;
  bit          exp_err;
  int          exp_wc;
  int          exp_used;

  always @(negedge Clk) if (WE === 1'b1) got_q.push_back({WAddr, WData});

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int budget;
    logic rdy;
    RxValid = 1'b0;
    repeat (gap) begin
      RxData = 8'($urandom);
      tick();
    end
    RxValid = 1'b1;
    RxData  = b;
    budget  = 0;
    do begin
      rdy = RxReady;
      tick();
      budget++;
    end while (!rdy && budget < 50);
    RxValid = 1'b0;
    chk("rx_accept", {31'b0, rdy}, 32'd1);
  endtask

  // Reference: header, N big-endian words, optional XOR byte.
  task automatic model();
    int n;
    logic [7:0] x;
    n = int'(stim[0]);
    exp_q.delete();
    x = 8'd0;
    if (n == 0 || n > DEPTH) begin
      exp_err = 1; exp_done = 0; exp_wc = 0; exp_used = 1;
      return;
    end
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({32'(i * 4), stim[1+4*i], stim[2+4*i], stim[3+4*i], stim[4+4*i]});
      for (int k = 1; k <= 4; k++) x = x ^ stim[4*i+k];
    end
    exp_wc   = n;
    exp_used = 1 + 4 * n;
`ifdef LOADER_CHECKSUM_EN
    exp_used++;
    exp_done = (stim[exp_used-1] == x);
    exp_err  = !exp_done;
`else
    exp_done = 1;
    exp_err  = 0;
`endif
  endtask

  task automatic run_load(input int mingap, input int maxgap);
    model();
    got_q.delete();
    Start = 1'b1;
    tick();
    Start = 1'b0;
    chk("hold_on_start", {31'b0, CpuHold}, 32'd1);
    for (int k = 0; k < exp_used; k++) send_byte(stim[k], int'($urandom_range(mingap, maxgap)));
    chk("done", {31'b0, Done}, {31'b0, exp_done});
    chk("error", {31'b0, Error}, {31'b0, exp_err});
    chk("cpuhold", {31'b0, CpuHold}, {31'b0, exp_err});
    chk("rxready_end", {31'b0, RxReady}, 32'd0);
    tick();
    tick();
    chk("we_count", got_q.size(), exp_q.size());
    foreach (exp_q[i]) begin
      if (i < got_q.size()) begin
        chk("waddr", got_q[i][63:32], exp_q[i][63:32]);
        chk("wdata", got_q[i][31:0], exp_q[i][31:0]);
      end
    end
    chk("wordcount", 32'(WordCount), 32'(exp_wc));
  endtask

  task automatic build_a(input logic [7:0] ck);
    stim = {8'h02, 8'h23, 8'hDE, 8'h00, 8'h0F, 8'h40, 8'h9E, 8'h60, 8'h00};
`ifdef LOADER_CHECKSUM_EN
    stim.push_back(ck);
`else
    if (ck == 8'h00) stim.push_back(8'h00);
`endif
  endtask

  task automatic build_words(input int n, input bit rnd, input bit bad);
    logic [7:0] x, b;
    x = 8'd0;
    stim = {};
    stim.push_back(8'(n));
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 4; k++) begin
        b = rnd ? 8'($urandom) : 8'(i);
        x = x ^ b;
        stim.push_back(b);
      end
    end
`ifdef LOADER_CHECKSUM_EN
    stim.push_back(bad ? (x ^ 8'h01) : x);
`else
    if (bad) stim.push_back(x);
`endif
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; RxValid = 1'b0; RxData = 8'h00;
    tick();
    tick();
    chk("rst_rxready", {31'b0, RxReady}, 32'd0);
    chk("rst_we", {31'b0, WE}, 32'd0);
    chk("rst_waddr", WAddr, 32'd0);
    chk("rst_wdata", WData, 32'd0);
    chk("rst_cpuhold", {31'b0, CpuHold}, 32'd0);
    chk("rst_done", {31'b0, Done}, 32'd0);
    chk("rst_error", {31'b0, Error}, 32'd0);
    chk("rst_wordcount", 32'(WordCount), 32'd0);
    Reset = 1'b0;
    tick();

    // Reference stream, continuous valid
    build_a(8'h4C);
    run_load(0, 0);

`ifdef LOADER_CHECKSUM_EN
    // Wrong checksum, then recovery from ERROR
    build_a(8'h4D);
    run_load(0, 0);
    build_a(8'h4C);
    run_load(0, 0);
`endif

    // Illegal headers
    stim = {8'h00};
    run_load(0, 0);
    stim = {8'h21};
    run_load(0, 0);

    // Reference stream with stalls of 1..5 cycles
    build_a(8'h4C);
    run_load(1, 5);

    // Reset after six bytes of the reference stream
    build_a(8'h4C);
    got_q.delete();
    Start = 1'b1;
    tick();
    Start = 1'b0;
    for (int k = 0; k < 6; k++) send_byte(stim[k], 0);
    chk("pre_reset_we_count", got_q.size(), 32'd1);
    if (got_q.size() > 0) begin
      chk("pre_reset_waddr", got_q[0][63:32], 32'h0000_0000);
      chk("pre_reset_wdata", got_q[0][31:0], 32'h23DE_000F);
    end
    #2;
    Reset = 1'b1;
    #1;
    chk("async_rxready", {31'b0, RxReady}, 32'd0);
    chk("async_cpuhold", {31'b0, CpuHold}, 32'd0);
    chk("async_waddr", WAddr, 32'd0);
    chk("async_wdata", WData, 32'd0);
    chk("async_wordcount", 32'(WordCount), 32'd0);
    tick();
    Reset = 1'b0;
    RxValid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      RxData = 8'($urandom);
      tick();
    end
    RxValid = 1'b0;
    tick();
    chk("post_reset_we_count", got_q.size(), 32'd1);
    chk("post_reset_rxready", {31'b0, RxReady}, 32'd0);
    chk("post_reset_cpuhold", {31'b0, CpuHold}, 32'd0);
    chk("post_reset_done", {31'b0, Done}, 32'd0);

    // Full memory, data = index * 0x01010101
    build_words(DEPTH, 1'b0, 1'b0);
    run_load(0, 0);
    chk("full_last_waddr", exp_q[DEPTH-1][63:32], 32'h0000_007C);
    if (got_q.size() == DEPTH) chk("full_last_wdata", got_q[DEPTH-1][31:0], 32'h1F1F_1F1F);

    // Randomised loads, occasionally with an illegal header or bad checksum
    for (int r = 0; r < 6; r++) begin
      build_words(int'($urandom_range(1, DEPTH)), 1'b1, ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 5) == 0) stim[0] = 8'($urandom_range(DEPTH + 1, 255));
      run_load(0, 3);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the CPU's 32-word instruction memory.
- Receives a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words.
- Issues one single-cycle write per word, with a byte address that matches the fetch-side indexing (word index in Addr[6:2]).
- Holds the CPU in reset while a load is in progress, then releases it.

Parameters:
- DEPTH, 32, instruction RAM size in words; legal 1..64.
- AW, 5, word-index width; must equal clog2(DEPTH).

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Start  in  1  single-cycle arm pulse.
- RxData  in  8  stream byte.
- RxValid  in  1  RxData valid.
- RxReady  out  1  loader accepts a byte this cycle.
- WE  out  1  instruction RAM write enable, one-cycle pulse per word.
- WAddr  out  32  byte address of the write, {zeros, index, 2'b00}.
- WData  out  32  instruction word to write.
- CpuHold  out  1  keeps the CPU in reset while high.
- Done  out  1  load completed successfully.
- Error  out  1  load failed.
- WordCount  out  AW+1  number of words written in the current load.

Behaviour:
- Reset: state IDLE; all outputs 0; internal shift register, checksum, byte counter and index all cleared.
- Byte transfer: occurs on a rising edge with RxValid && RxReady. RxReady is a registered function of state and is high only in HDR, DATA and CHECK.
- IDLE: RxReady=0, CpuHold=0. Start -> HDR; CpuHold goes 1 at the next edge.
- HDR: accepts 1 byte N.
  - N==0 or N>DEPTH -> ERROR.
  - Otherwise: store N, clear index, byte counter and checksum -> DATA.
- DATA: accepts bytes MSB first. Each byte shifts in (word = {word[23:0], byte]) and is XORed into the checksum.
  - On the 4th byte of a word: next cycle WE=1 for exactly 1 cycle, WAddr={index,2'b00}, WData=assembled word; index and WordCount increment in that same cycle.
  - RxReady stays 1 during the WE cycle, so back-to-back words need no gaps.
  - After the 4th byte of word N-1 -> CHECK (LOADER_CHECKSUM_EN defined) or DONE (not defined).
- CHECK: accepts 1 byte. Equal to the running XOR -> DONE, else -> ERROR. The last WE pulse still occurs during the CHECK entry cycle.
- DONE: Done=1, CpuHold=0, RxReady=0. Held until Start, which -> HDR (clears Done, WordCount).
- ERROR: Error=1, CpuHold=1, RxReady=0. Held until Start -> HDR (clears Error, WordCount) or Reset.
- Start is ignored in HDR, DATA and CHECK.
- WData/WAddr: hold their last value when WE=0.
- Reset mid-load: outputs clear asynchronously.
  - The partial word is discarded and no further WE is issued.
  - Words already written remain in RAM.
  - After reset the CPU runs whatever RAM contains.
- RxValid low: no state change; stalls of any length are legal.
- Index never wraps: the maximum WAddr is (DEPTH-1)*4, e.g. 0x7C for DEPTH=32.

Optional Feature:
- Macro LOADER_CHECKSUM_EN.
- Defined: a trailing XOR checksum byte follows the data, and the CHECK state is present as described above.
- Not defined: no checksum byte is expected and DATA goes directly to DONE after the last word. No checksum register is built, and Error arises only from an illegal header.

Test Plan:
- Checksum on: Start; bytes 02 23 DE 00 0F 40 9E 60 00 4C, RxValid continuous -> WE at WAddr 0x00 with WData 0x23DE000F, then WAddr 0x04 with WData 0x409E6000. Result: Done=1, CpuHold=0, WordCount=2, Error=0.
- Same stream with last byte 4D -> two WE pulses as above, then Error=1, CpuHold=1, Done=0. A following Start plus the correct stream -> Done=1.
- Header 00, and header 21 with DEPTH=32 -> Error=1 one cycle after the header byte, no WE pulse, RxReady=0.
- Random RxValid gaps (1..5 cycles) on the first stream -> identical WE/WAddr/WData sequence and final Done=1.
- Reset asserted after 6 bytes of the first stream -> exactly one WE (0x23DE000F at 0x00) occurred. Outputs go 0 asynchronously, state IDLE, later bytes ignored.
- Full load: header 20 and 32 words with data = index*0x01010101 -> last WE at WAddr 0x7C with WData 0x1F1F1F1F, WordCount=32, Done=1.
